// File: rtl/vend_fsm_param_if.sv
// Signal bundle between the coin acceptor front-end, the vending controller
// and the dispenser / change-hopper drivers.
interface vend_fsm_param_if #(
  parameter int CREDIT_W = 6
) ();
  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                cancel;
  logic                out;
  logic                change;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                sold_out;

  modport master (
    output coin_valid, coin_sel, cancel,
    input  out, change, coin_reject, credit, busy, sold_out
  );

  modport slave (
    input  coin_valid, coin_sel, cancel,
    output out, change, coin_reject, credit, busy, sold_out
  );
endinterface

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: credit in 5 rs units, programmable price, serial change train.
// Optional stock counter with sold-out refund is enabled by defining VM_STOCK_EN.
module vend_fsm_param #(
  parameter int CREDIT_W   = 6,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 8,
  parameter int STOCK_INIT = 10
) (
  input  logic            clk,
  input  logic            rst,
  vend_fsm_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [CREDIT_W:0]   MAX_S    = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_S  = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_CR = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CR_ONE   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] CR_ZERO  = '0;

  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] sel);
    logic [CREDIT_W:0] v;
    case (sel)
      2'b00:   v = (CREDIT_W+1)'(1);
      2'b01:   v = (CREDIT_W+1)'(2);
      2'b10:   v = (CREDIT_W+1)'(4);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Floor at zero so the credit register can never wrap on a decrement.
  function automatic logic [CREDIT_W-1:0] credit_dec(input logic [CREDIT_W-1:0] c);
    logic [CREDIT_W-1:0] r;
    if (c == CR_ZERO) r = CR_ZERO;
    else              r = c - CR_ONE;
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                out_q, out_d;
  logic                change_q, change_d;
  logic                reject_q, reject_d;
  logic                busy_q;
  logic                sold_out_q;
  logic                vend_take;

  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W:0]   total;
  logic [CREDIT_W-1:0] vend_rem;
  logic                coin_ok;
  logic                coin_fits;
  logic                accept;

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    out_d     = 1'b0;
    change_d  = 1'b0;
    reject_d  = 1'b0;
    vend_take = 1'b0;
    coin_ok   = (bus.coin_sel != 2'b11);
    sum       = {1'b0, credit_q} + coin_value(bus.coin_sel);
    coin_fits = (sum <= MAX_S);
    vend_rem  = sum[CREDIT_W-1:0] - PRICE_CR;
    accept    = 1'b0;
    total     = {1'b0, credit_q};

    case (state_q)
      IDLE, COLLECT: begin
        accept   = bus.coin_valid && coin_ok && coin_fits && !sold_out_q;
        reject_d = bus.coin_valid && !accept;
        if (accept) total = sum;
        // Refund wins over vend: an accepted coin is folded into the refund.
        if ((bus.cancel || sold_out_q) && (total != '0)) begin
          state_d  = CHANGE;
          credit_d = credit_dec(total[CREDIT_W-1:0]);
          change_d = 1'b1;
        end else if (accept && (sum >= PRICE_S)) begin
          state_d   = VEND;
          credit_d  = vend_rem;
          out_d     = 1'b1;
          vend_take = 1'b1;
        end else if (accept) begin
          state_d  = COLLECT;
          credit_d = sum[CREDIT_W-1:0];
        end
      end
      VEND, CHANGE: begin
        reject_d = bus.coin_valid;
        // Each change pulse is paired with the matching credit decrement.
        if (credit_q != CR_ZERO) begin
          state_d  = CHANGE;
          credit_d = credit_dec(credit_q);
          change_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      out_q    <= 1'b0;
      change_q <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      out_q    <= out_d;
      change_q <= change_d;
      reject_q <= reject_d;
      busy_q   <= (state_d == VEND) || (state_d == CHANGE);
    end
  end

`ifdef VM_STOCK_EN
  localparam int STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

  logic [STOCK_W-1:0] stock_q, stock_d;

  // vend_take is only raised while stock is non-zero, so this cannot underflow.
  always_comb begin
    stock_d = stock_q;
    if (vend_take) stock_d = stock_q - STOCK_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stock_q    <= STOCK_W'(STOCK_INIT);
      sold_out_q <= (STOCK_INIT == 0);
    end else begin
      stock_q    <= stock_d;
      sold_out_q <= (stock_d == '0);
    end
  end
`else
  logic unused_stock;
  assign unused_stock = vend_take ^ (STOCK_INIT != 0);
  assign sold_out_q   = 1'b0;
`endif

  assign bus.out         = out_q;
  assign bus.change      = change_q;
  assign bus.coin_reject = reject_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;
  assign bus.sold_out    = sold_out_q;

endmodule
